// File: rtl/nonsynth_ethernet_transmitter_if.sv
// Host-side buffer/send controls and the AXI-Stream TX beat channel of the
// cosim Ethernet frame source.
//
// Handshake: a beat transfers on a rising clock edge where tx_axis_tvalid_o
// and tx_axis_tready_i are both 1. Once tvalid is raised, it stays high and
// tdata/tkeep/tlast stay unchanged until that transfer happens. send_i is a
// level input and is only looked at while ready_r_o is 1.
interface nonsynth_ethernet_transmitter_if #(
  parameter int addr_width_p = 8
);
  logic                    buffer_write_en_i;
  logic [addr_width_p-1:0] buffer_write_addr_i;
  logic [63:0]             buffer_write_data_i;
  logic [15:0]             tx_packet_size_i;
  logic                    send_i;
  logic                    ready_r_o;
  logic                    size_err_r_o;
  logic [63:0]             tx_axis_tdata_o;
  logic [7:0]              tx_axis_tkeep_o;
  logic                    tx_axis_tvalid_o;
  logic                    tx_axis_tready_i;
  logic                    tx_axis_tlast_o;
  logic                    tx_axis_tuser_o;
  logic                    state_dbg_o;

  modport slave (
    input  buffer_write_en_i, buffer_write_addr_i, buffer_write_data_i,
    input  tx_packet_size_i, send_i, tx_axis_tready_i,
    output ready_r_o, size_err_r_o, tx_axis_tdata_o, tx_axis_tkeep_o,
    output tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tuser_o, state_dbg_o
  );

  modport master (
    output buffer_write_en_i, buffer_write_addr_i, buffer_write_data_i,
    output tx_packet_size_i, send_i, tx_axis_tready_i,
    input  ready_r_o, size_err_r_o, tx_axis_tdata_o, tx_axis_tkeep_o,
    input  tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tuser_o, state_dbg_o
  );
endinterface

// File: rtl/nonsynth_ethernet_transmitter.sv
// Cosim Ethernet TX frame source: the host writes a word-wide frame buffer,
// then requests a send of N bytes. The frame is streamed as 8-byte
// AXI-Stream beats, with a partial tkeep on the final beat.
module nonsynth_ethernet_transmitter #(
  parameter int send_width_p  = 8,
  parameter int buf_size_p    = ((1556 - 1) / send_width_p + 1) * send_width_p,
  parameter int addr_width_lp = $clog2(buf_size_p / send_width_p)
) (
  input logic clk_i,
  input logic reset_i,
  nonsynth_ethernet_transmitter_if.slave bus_if
);

  localparam int unsigned words_lp = buf_size_p / send_width_p;

  // Only 8-byte beats are supported.
  if (send_width_p != 8) begin : g_width_check
    $error("nonsynth_ethernet_transmitter: send_width_p must be 8");
  end

  typedef enum logic {IDLE_S = 1'b0, SEND_S = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [addr_width_lp-1:0] ptr_q, ptr_d;
  logic [15:0]              size_q, size_d;
  logic                     size_err_q, size_err_d;
  logic [63:0]              mem_q [words_lp];

  logic        size_ok;
  logic        send_ok;
  logic        send_bad;
  logic [15:0] last_idx;
  logic        is_last;
  logic        beat_acc;
  logic [2:0]  rem;

  assign size_ok  = (bus_if.tx_packet_size_i != 16'd0) &&
                    (bus_if.tx_packet_size_i <= 16'(buf_size_p));
  assign send_ok  = (state_q == IDLE_S) && bus_if.send_i && size_ok;
  assign send_bad = (state_q == IDLE_S) && bus_if.send_i && !size_ok;
  assign last_idx = ((size_q + 16'd7) >> 3) - 16'd1;
  assign is_last  = (16'(ptr_q) == last_idx);
  assign beat_acc = (state_q == SEND_S) && bus_if.tx_axis_tready_i;
  assign rem      = size_q[2:0];

  // State register; reset aborts any frame immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE_S;
    else         state_q <= state_d;
  end

  // Next-state: a legal send starts a frame; the final accepted beat ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S:  if (send_ok) state_d = SEND_S;
      SEND_S:  if (beat_acc && is_last) state_d = IDLE_S;
      default: state_d = IDLE_S;
    endcase
  end

  // Datapath next values: size latch, beat pointer and sticky size error.
  always_comb begin
    ptr_d      = ptr_q;
    size_d     = size_q;
    size_err_d = size_err_q;
    if (send_ok) begin
      ptr_d      = '0;
      size_d     = bus_if.tx_packet_size_i;
      size_err_d = 1'b0;
    end else if (send_bad) begin
      size_err_d = 1'b1;
    end else if (beat_acc && !is_last) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q      <= '0;
      size_q     <= '0;
      size_err_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      size_q     <= size_d;
      size_err_q <= size_err_d;
    end
  end

  // Frame buffer: writable only while idle, so a frame in flight is locked.
  always_ff @(posedge clk_i) begin
    if ((state_q == IDLE_S) && bus_if.buffer_write_en_i &&
        (32'(bus_if.buffer_write_addr_i) < words_lp))
      mem_q[bus_if.buffer_write_addr_i] <= bus_if.buffer_write_data_i;
  end

  // Outputs: beat fields come from the current pointer and latched size.
  always_comb begin
    bus_if.ready_r_o        = (state_q == IDLE_S);
    bus_if.size_err_r_o     = size_err_q;
    bus_if.tx_axis_tvalid_o = (state_q == SEND_S);
    bus_if.tx_axis_tlast_o  = (state_q == SEND_S) && is_last;
    bus_if.tx_axis_tdata_o  = mem_q[ptr_q];
    bus_if.tx_axis_tuser_o  = 1'b0;
    bus_if.state_dbg_o      = state_q;
    bus_if.tx_axis_tkeep_o  = 8'h00;
    if (state_q == SEND_S) begin
      if (is_last && (rem != 3'd0)) bus_if.tx_axis_tkeep_o = (8'h01 << rem) - 8'h01;
      else                          bus_if.tx_axis_tkeep_o = 8'hFF;
    end
  end

endmodule

// File: tb/tb_nonsynth_ethernet_transmitter.sv
module tb_nonsynth_ethernet_transmitter;
  localparam int AW    = 8;
  localparam int WORDS = 195;
  localparam int BUF   = 1560;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nonsynth_ethernet_transmitter_if #(.addr_width_p(AW)) bus ();

  nonsynth_ethernet_transmitter dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents and the expected beat stream.
  logic [63:0] exp_mem [WORDS];
  logic [63:0] exp_q [$];
  logic [7:0]  keep_q [$];
  logic        last_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [63:0] data);
    @(negedge clk);
    bus.buffer_write_en_i   = 1'b1;
    bus.buffer_write_addr_i = AW'(addr);
    bus.buffer_write_data_i = data;
    exp_mem[addr] = data;
    @(negedge clk);
    bus.buffer_write_en_i = 1'b0;
  endtask

  // Byte-level view: byte b of the frame lives in word b/8, lane b%8.
  task automatic build_expected(input int size);
    int beats;
    logic [7:0] k;
    exp_q.delete(); keep_q.delete(); last_q.delete();
    beats = (size + 7) / 8;
    for (int w = 0; w < beats; w++) begin
      k = 8'h00;
      for (int j = 0; j < 8; j++) if (w * 8 + j < size) k[j] = 1'b1;
      exp_q.push_back(exp_mem[w]);
      keep_q.push_back(k);
      last_q.push_back(w == beats - 1);
    end
  endtask

  task automatic send_frame(input int size, input int pct, input bit intrude);
    int cyc;
    int last_w;
    bit first;
    build_expected(size);
    last_w = (size + 7) / 8 - 1;
    @(negedge clk);
    check("ready_before_send", bus.ready_r_o, 1);
    bus.send_i           = 1'b1;
    bus.tx_packet_size_i = 16'(size);
    bus.tx_axis_tready_i = 1'b0;
    @(negedge clk);
    bus.send_i = 1'b0;
    check("size_err_clear", bus.size_err_r_o, 0);
    check("ready_low_in_send", bus.ready_r_o, 0);
    cyc = 0;
    first = 1'b1;
    while (exp_q.size() > 0 && cyc < 4000) begin
      bus.tx_axis_tready_i = ($urandom_range(99) < pct);
      if (intrude && first) begin
        // Locked buffer: this write and re-send must have no effect.
        bus.buffer_write_en_i   = 1'b1;
        bus.buffer_write_addr_i = AW'(last_w);
        bus.buffer_write_data_i = ~exp_mem[last_w];
        bus.send_i              = 1'b1;
        bus.tx_packet_size_i    = 16'd8;
      end else begin
        bus.buffer_write_en_i = 1'b0;
        bus.send_i            = 1'b0;
      end
      first = 1'b0;
      #1;
      check("tvalid", bus.tx_axis_tvalid_o, 1);
      check("tdata", bus.tx_axis_tdata_o, exp_q[0]);
      check("tkeep", bus.tx_axis_tkeep_o, keep_q[0]);
      check("tlast", bus.tx_axis_tlast_o, last_q[0]);
      check("tuser", bus.tx_axis_tuser_o, 0);
      if (bus.tx_axis_tready_i) begin
        void'(exp_q.pop_front());
        void'(keep_q.pop_front());
        void'(last_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    check("frame_beats_left", 64'(exp_q.size()), 0);
    bus.buffer_write_en_i = 1'b0;
    bus.send_i            = 1'b0;
    bus.tx_axis_tready_i  = 1'b0;
    check("tvalid_after_frame", bus.tx_axis_tvalid_o, 0);
    check("ready_after_frame", bus.ready_r_o, 1);
    check("tlast_after_frame", bus.tx_axis_tlast_o, 0);
  endtask

  task automatic bad_send(input int size);
    @(negedge clk);
    bus.send_i           = 1'b1;
    bus.tx_packet_size_i = 16'(size);
    bus.tx_axis_tready_i = 1'b1;
    @(negedge clk);
    bus.send_i = 1'b0;
    check("size_err_set", bus.size_err_r_o, 1);
    check("ready_after_bad", bus.ready_r_o, 1);
    for (int i = 0; i < 3; i++) begin
      check("no_tvalid_bad", bus.tx_axis_tvalid_o, 0);
      @(negedge clk);
    end
    bus.tx_axis_tready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.buffer_write_en_i   = 1'b0;
    bus.buffer_write_addr_i = '0;
    bus.buffer_write_data_i = '0;
    bus.tx_packet_size_i    = '0;
    bus.send_i              = 1'b0;
    bus.tx_axis_tready_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.ready_r_o, 1);
    check("rst_size_err", bus.size_err_r_o, 0);
    check("rst_tvalid", bus.tx_axis_tvalid_o, 0);
    check("rst_tlast", bus.tx_axis_tlast_o, 0);
    check("rst_tkeep", bus.tx_axis_tkeep_o, 0);
    rst = 1'b0;

    // Full 64-byte frame, no backpressure.
    for (int i = 0; i < 8; i++) write_word(i, {$urandom, $urandom});
    send_frame(64, 100, 1'b0);

    // Partial last beat, single byte, and full-buffer frame.
    send_frame(61, 100, 1'b0);
    send_frame(1, 100, 1'b0);
    for (int i = 0; i < WORDS; i++) write_word(i, {$urandom, $urandom});
    send_frame(BUF, 100, 1'b0);

    // Random backpressure.
    send_frame(64, 50, 1'b0);

    // Illegal sizes, then a legal send clears the sticky error.
    bad_send(0);
    bad_send(BUF + 1);
    send_frame(8, 100, 1'b0);

    // Writes and send_i during a frame are ignored.
    send_frame(64, 100, 1'b1);
    send_frame(64, 100, 1'b0);

    // Reset while beat 3 is presented aborts the frame.
    @(negedge clk);
    bus.send_i           = 1'b1;
    bus.tx_packet_size_i = 16'd64;
    @(negedge clk);
    bus.send_i           = 1'b0;
    bus.tx_axis_tready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_beat3_data", bus.tx_axis_tdata_o, exp_mem[2]);
    rst = 1'b1;
    #1;
    check("abort_tvalid", bus.tx_axis_tvalid_o, 0);
    check("abort_ready", bus.ready_r_o, 1);
    check("abort_tlast", bus.tx_axis_tlast_o, 0);
    check("abort_tkeep", bus.tx_axis_tkeep_o, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.tx_axis_tready_i = 1'b0;
    send_frame(64, 70, 1'b0);

    // Random sizes and backpressure.
    for (int t = 0; t < 4; t++) send_frame(int'($urandom_range(BUF, 1)), int'($urandom_range(90, 30)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
